// File: rtl/tinycpu_pkg.sv
// Shared TinyCPU definitions used by the fetch stage.
//   INSTR_W / ADDR_W : instruction word and word-address widths
//   fetch_state_e    : fetch FSM states
//   fetch_entry_t    : one instruction-buffer entry {pc, instr}
package tinycpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{pc: 32'h0, instr: 32'h0};

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory responses and the decoder.
// Head outputs are registered: a push shows up on the head the cycle after.
//   clk, rst              : clock, asynchronous active-high reset
//   push, push_pc/instr   : write one entry (ignored while full)
//   pop                   : drop the head entry (ignored while empty)
//   flush                 : discard all entries; overrides push and pop
//   full, empty, count    : occupancy
//   head_valid/pc/instr   : registered oldest entry
module fetch_fifo
    import tinycpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [ADDR_W-1:0]           push_pc,
    input  logic [INSTR_W-1:0]          push_instr,
    input  logic                        pop,
    input  logic                        flush,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        head_valid,
    output logic [ADDR_W-1:0]           head_pc,
    output logic [INSTR_W-1:0]          head_instr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_r [FIFO_DEPTH];
    fetch_entry_t     head_r;
    fetch_entry_t     head_next_s;
    logic             head_valid_r;
    logic             head_valid_next_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full       = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign count      = count_r;
    assign head_valid = head_valid_r;
    assign head_pc    = head_r.pc;
    assign head_instr = head_r.instr;

    // Qualify push/pop against occupancy; flush suppresses both.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = push & ~full;
            do_pop_s  = pop & ~empty;
        end
    end

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        if (flush) begin
            rd_ptr_next_s = {PTR_W{1'b0}};
            wr_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            if (do_push_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_next_s = count_r + CNT_W'(1'b1);
                2'b01:   count_next_s = count_r - CNT_W'(1'b1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Next head: the slot being written this cycle bypasses storage when it becomes the head.
    always_comb begin
        head_next_s       = head_r;
        head_valid_next_s = 1'b0;
        if (count_next_s == {CNT_W{1'b0}}) begin
            head_valid_next_s = 1'b0;
            head_next_s       = head_r;
        end else if (do_push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_valid_next_s = 1'b1;
            head_next_s       = '{pc: push_pc, instr: push_instr};
        end else begin
            head_valid_next_s = 1'b1;
            head_next_s       = mem_r[rd_ptr_next_s];
        end
    end

    // Storage, pointers and registered head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            head_r       <= ENTRY_ZERO;
            head_valid_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= '{pc: push_pc, instr: push_instr};
            end
            rd_ptr_r     <= rd_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            count_r      <= count_next_s;
            head_r       <= head_next_s;
            head_valid_r <= head_valid_next_s;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// TinyCPU instruction fetch stage: program counter, single-outstanding
// req/gnt + rvalid memory reads, and a buffer feeding the decoder.
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_req/addr            : registered read request, held until imem_gnt
//   imem_gnt                 : request accepted
//   imem_rvalid/rdata        : read response
//   redirect/redirect_pc     : taken jump; flushes buffer and squashes in-flight read
//   instr_valid/ready        : decoder handshake
//   instruction, instr_pc    : oldest buffered instruction and its word address
module fetch_unit
    import tinycpu_pkg::*;
#(
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_r;
    fetch_state_e      state_next_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] fetch_pc_next_s;
    logic [ADDR_W-1:0] imem_addr_r;
    logic              imem_req_r;
    logic              squash_r;
    logic              squash_next_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign pop_s     = instr_ready & ~fifo_empty_s;

    // FSM next state, PC update, squash tracking and buffer push.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        squash_next_s   = squash_r;
        push_s          = 1'b0;
        case (state_r)
            IDLE: begin
                // Nothing is outstanding here, so occupancy alone bounds the issue;
                // a redirect empties the buffer so it can always issue.
                if (redirect || (fifo_count_s < CNT_W'(FIFO_DEPTH))) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    state_next_s = WAIT;
                    // A request already squashed was for the pre-redirect stream;
                    // fetch_pc already points at the jump target.
                    if (squash_r) begin
                        fetch_pc_next_s = fetch_pc_r;
                    end else begin
                        fetch_pc_next_s = fetch_pc_r + 32'h1;
                    end
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next_s  = IDLE;
                    squash_next_s = 1'b0;
                    push_s        = ~squash_r & ~redirect & ~fifo_full_s;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // A redirect overrides the PC; any read still to come back is marked stale.
        if (redirect) begin
            fetch_pc_next_s = redirect_pc;
            squash_next_s   = (state_r == REQ) || ((state_r == WAIT) && !imem_rvalid);
        end else begin
            fetch_pc_next_s = fetch_pc_next_s;
        end
    end

    // State, PC and squash registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            squash_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            squash_r   <= squash_next_s;
        end
    end

    // Request outputs: the address is captured only while idle, so it stays
    // fixed through REQ (even across a redirect) and tags the response in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
        end else begin
            imem_req_r <= (state_next_s == REQ);
            if (state_r == IDLE) begin
                imem_addr_r <= fetch_pc_next_s;
            end else begin
                imem_addr_r <= imem_addr_r;
            end
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_pc    (imem_addr_r),
        .push_instr (imem_rdata),
        .pop        (pop_s),
        .flush      (redirect),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instruction)
    );

endmodule
